exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_if.sv | 30 +++
 rtl/exec_sequencer.sv | 98 +++++++++
 tb/tb_exec_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// Instruction handshake, register-file and status signals of the execution sequencer.
// The slave modport belongs to the sequencer; the master modport belongs to its environment.
interface exec_sequencer_if;
  logic [7:0] INSTR;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic [7:0] READ_DATA_ONE;
  logic [7:0] READ_DATA_TWO;
  logic [1:0] REG_SOURCE;
  logic [1:0] REG_TWO;
  logic [1:0] REG_DEST;
  logic       REGDST;
  logic       REGWRITE;
  logic [7:0] REG_WRITE_DATA;
  logic       ZERO;
  logic       CARRY;
  logic [7:0] RETIRED;

  modport slave (
    input  INSTR, INSTR_VALID, READ_DATA_ONE, READ_DATA_TWO,
    output INSTR_READY, REG_SOURCE, REG_TWO, REG_DEST, REGDST, REGWRITE,
           REG_WRITE_DATA, ZERO, CARRY, RETIRED
  );

  modport master (
    output INSTR, INSTR_VALID, READ_DATA_ONE, READ_DATA_TWO,
    input  INSTR_READY, REG_SOURCE, REG_TWO, REG_DEST, REGDST, REGWRITE,
           REG_WRITE_DATA, ZERO, CARRY, RETIRED
  );
endinterface

// File: rtl/exec_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer executing ADD, LI, SUB and ADDI on an
// 8-bit register file with a registered read port; one instruction retires every 4 cycles.
module exec_sequencer (
  input  logic            CLK,
  input  logic            RST,
  exec_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     r_state;
  logic [7:0] r_instr;
  logic       r_ready;
  logic [1:0] r_src;
  logic [1:0] r_two;
  logic [1:0] r_dest;
  logic       r_regdst;
  logic       r_regwrite;
  logic [7:0] r_result;
  logic       r_zero;
  logic       r_carry;
  logic [7:0] r_retired;

  logic [7:0] w_imm;
  logic [8:0] w_diff;
  logic [8:0] w_res;

  assign w_imm  = {{6{r_instr[1]}}, r_instr[1:0]};
  assign w_diff = {1'b0, bus.READ_DATA_ONE} - {1'b0, bus.READ_DATA_TWO};

  // Bit 8 of w_res is the CARRY flag; for SUB it is the inverted borrow (A >= B).
  always_comb begin
    w_res = '0;
    case (r_instr[7:6])
      2'b00:   w_res = {1'b0, bus.READ_DATA_ONE} + {1'b0, bus.READ_DATA_TWO};
      2'b01:   w_res = {1'b0, w_imm};
      2'b10:   w_res = {~w_diff[8], w_diff[7:0]};
      default: w_res = {1'b0, bus.READ_DATA_ONE} + {1'b0, w_imm};
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_ready    <= 1'b1;
      r_src      <= '0;
      r_two      <= '0;
      r_dest     <= '0;
      r_regdst   <= 1'b0;
      r_regwrite <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.INSTR_VALID) begin
            r_instr <= bus.INSTR;
            r_src   <= bus.INSTR[5:4];
            r_two   <= bus.INSTR[3:2];
            r_ready <= 1'b0;
            r_state <= READ;
          end
        end
        READ: r_state <= EXEC;
        EXEC: begin
          // Write-back outputs are loaded here so they are valid throughout the WB cycle.
          r_result   <= w_res[7:0];
          r_carry    <= w_res[8];
          r_zero     <= (w_res[7:0] == 8'h00);
          r_regwrite <= 1'b1;
          r_retired  <= r_retired + 8'd1;
          r_regdst   <= ~r_instr[6];
          if (!r_instr[6]) r_dest <= r_instr[1:0];
          r_state    <= WB;
        end
        WB: begin
          r_regwrite <= 1'b0;
          r_ready    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.INSTR_READY    = r_ready;
  assign bus.REG_SOURCE     = r_src;
  assign bus.REG_TWO        = r_two;
  assign bus.REG_DEST       = r_dest;
  assign bus.REGDST         = r_regdst;
  assign bus.REGWRITE       = r_regwrite;
  assign bus.REG_WRITE_DATA = r_result;
  assign bus.ZERO           = r_zero;
  assign bus.CARRY          = r_carry;
  assign bus.RETIRED        = r_retired;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: vector table of single instructions plus
// hand-written sequences for reset during execution and a 256-instruction burst.
module tb_exec_sequencer;
  logic CLK;
  logic RST;
  exec_sequencer_if bus ();

  exec_sequencer dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned total;
  int unsigned bad;
  logic [7:0]  exp_ret;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       regdst;
    logic [1:0] dest;
    logic       zero;
    logic       carry;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the sequencer idle; returns at a falling edge, idle again.
  task automatic run_vec(input vec_t v);
    logic [7:0] ins;
    ins = v.instr;
    bus.INSTR         = ins;
    bus.READ_DATA_ONE = v.a;
    bus.READ_DATA_TWO = v.b;
    bus.INSTR_VALID   = 1'b1;
    chk("ready_idle", {31'd0, bus.INSTR_READY}, 32'd1);
    @(negedge CLK);
    chk("rs", {30'd0, bus.REG_SOURCE}, {30'd0, ins[5:4]});
    chk("rt", {30'd0, bus.REG_TWO}, {30'd0, ins[3:2]});
    chk("regwrite_read", {31'd0, bus.REGWRITE}, 32'd0);
    chk("ready_busy", {31'd0, bus.INSTR_READY}, 32'd0);
    bus.INSTR = ~ins;
    @(negedge CLK);
    chk("regwrite_exec", {31'd0, bus.REGWRITE}, 32'd0);
    @(negedge CLK);
    exp_ret = exp_ret + 8'd1;
    chk("regwrite_wb", {31'd0, bus.REGWRITE}, 32'd1);
    chk("wdata", {24'd0, bus.REG_WRITE_DATA}, {24'd0, v.data});
    chk("regdst", {31'd0, bus.REGDST}, {31'd0, v.regdst});
    chk("rd", {30'd0, bus.REG_DEST}, {30'd0, v.dest});
    chk("zero", {31'd0, bus.ZERO}, {31'd0, v.zero});
    chk("carry", {31'd0, bus.CARRY}, {31'd0, v.carry});
    chk("retired", {24'd0, bus.RETIRED}, {24'd0, exp_ret});
    chk("rt_held", {30'd0, bus.REG_TWO}, {30'd0, ins[3:2]});
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    chk("regwrite_after", {31'd0, bus.REGWRITE}, 32'd0);
    chk("ready_after", {31'd0, bus.INSTR_READY}, 32'd1);
    chk("wdata_held", {24'd0, bus.REG_WRITE_DATA}, {24'd0, v.data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pulses;
    int unsigned pos_err;
    int unsigned val_err;
    logic [7:0]  burst_ret;
    vec_t        rv;

    total = 0;
    bad = 0;
    exp_ret = '0;
    //         instr          a      b      data   rdst  rd     z     c
    tbl[0] = '{8'b01_00_10_11, 8'h00, 8'h00, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{8'b00_01_10_11, 8'hF0, 8'h20, 8'h10, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[2] = '{8'b10_01_10_00, 8'h55, 8'h55, 8'h00, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[3] = '{8'b10_00_01_01, 8'h01, 8'h02, 8'hFF, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[4] = '{8'b11_10_01_10, 8'h05, 8'h77, 8'h03, 1'b0, 2'd1, 1'b0, 1'b1};
    tbl[5] = '{8'b00_11_00_10, 8'h7F, 8'h01, 8'h80, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[6] = '{8'b11_00_00_01, 8'hFF, 8'h00, 8'h00, 1'b0, 2'd2, 1'b1, 1'b1};
    tbl[7] = '{8'b01_00_00_00, 8'h33, 8'h44, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0};

    RST = 1'b1;
    bus.INSTR = '0;
    bus.INSTR_VALID = 1'b0;
    bus.READ_DATA_ONE = '0;
    bus.READ_DATA_TWO = '0;
    repeat (3) @(negedge CLK);
    chk("rst_outputs", {bus.REG_SOURCE, bus.REG_TWO, bus.REG_DEST, bus.REGDST, bus.REGWRITE,
                        bus.ZERO, bus.CARRY, bus.REG_WRITE_DATA, bus.RETIRED}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", {31'd0, bus.INSTR_READY}, 32'd1);

    // Reset arriving while an ADD is in EXEC: asynchronous clear, no write strobe.
    bus.INSTR = 8'b00_11_01_10;
    bus.READ_DATA_ONE = 8'h01;
    bus.READ_DATA_TWO = 8'h02;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    chk("pre_rst_rs", {30'd0, bus.REG_SOURCE}, 32'd3);
    RST = 1'b1;
    #1;
    chk("async_rst", {bus.REG_SOURCE, bus.REG_TWO, bus.REG_DEST, bus.REGDST, bus.REGWRITE,
                      bus.ZERO, bus.CARRY, bus.REG_WRITE_DATA, bus.RETIRED}, 32'd0);
    chk("async_rst_ready", {31'd0, bus.INSTR_READY}, 32'd1);
    repeat (2) begin
      @(negedge CLK);
      chk("rst_no_write", {31'd0, bus.REGWRITE}, 32'd0);
    end
    chk("rst_retired", {24'd0, bus.RETIRED}, 32'd0);
    RST = 1'b0;

    for (int unsigned i = 0; i < 8; i++) begin
      rv = tbl[i];
      run_vec(rv);
    end

    // 256 back-to-back LI +1 with VALID held; strobe lands in the third cycle after each accept.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    bus.INSTR = 8'b01_00_00_01;
    bus.INSTR_VALID = 1'b1;
    pulses = 0;
    pos_err = 0;
    val_err = 0;
    burst_ret = '0;
    for (int unsigned c = 0; c < 1024; c++) begin
      @(negedge CLK);
      if (bus.REGWRITE !== ((c % 4) == 2)) pos_err++;
      if (bus.REGWRITE === 1'b1) begin
        pulses++;
        burst_ret = burst_ret + 8'd1;
        if (bus.RETIRED !== burst_ret || bus.REG_WRITE_DATA !== 8'h01) val_err++;
      end
    end
    bus.INSTR_VALID = 1'b0;
    chk("burst_pulses", pulses, 32'd256);
    chk("burst_spacing_errors", pos_err, 32'd0);
    chk("burst_value_errors", val_err, 32'd0);
    chk("burst_retired_wrap", {24'd0, bus.RETIRED}, 32'd0);
    @(negedge CLK);
    chk("burst_idle", {31'd0, bus.REGWRITE}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
